// File: rtl/key_event_if.sv
// Event bus between the key event decoder and its consumers (e.g. the RS485 frame builder).
// The decoder is the master: it samples key_filter and drives the classified events.
interface key_event_if;
  logic       key_filter;
  logic       key_short;
  logic       key_double;
  logic       key_long;
  logic       key_hold;
  logic       key_valid;
  logic [1:0] key_code;

  modport master (
    input  key_filter,
    output key_short,
    output key_double,
    output key_long,
    output key_hold,
    output key_valid,
    output key_code
  );

  modport slave (
    output key_filter,
    input  key_short,
    input  key_double,
    input  key_long,
    input  key_hold,
    input  key_valid,
    input  key_code
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures (active-low level) into short press, double click and
// long press, emitting registered one-cycle pulses plus a held 2-bit event code.
module key_event_decoder #(
  parameter logic [25:0] LONG_CNT = 26'd50_000_000,
  parameter logic [25:0] DCLK_CNT = 26'd12_500_000
) (
  input logic         sys_clk,
  input logic         sys_rst_n,
  key_event_if.master evt
);

  localparam logic [1:0] CodeShort  = 2'b01;
  localparam logic [1:0] CodeDouble = 2'b10;
  localparam logic [1:0] CodeLong   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StWait2,
    StPress2,
    StLongHold
  } state_e;

  state_e      state;
  logic [25:0] cnt;
  logic        key_d;
  logic        key_press;
  logic        key_release;

  assign key_press   = key_d & ~evt.key_filter;
  assign key_release = ~key_d & evt.key_filter;

  // Reset value 1 matches the idle (released) key level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_d <= 1'b1;
    end else begin
      key_d <= evt.key_filter;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= StIdle;
      cnt            <= '0;
      evt.key_short  <= 1'b0;
      evt.key_double <= 1'b0;
      evt.key_long   <= 1'b0;
      evt.key_hold   <= 1'b0;
      evt.key_valid  <= 1'b0;
      evt.key_code   <= 2'b00;
    end else begin
      evt.key_short  <= 1'b0;
      evt.key_double <= 1'b0;
      evt.key_long   <= 1'b0;
      evt.key_valid  <= 1'b0;

      case (state)
        StIdle: begin
          cnt <= '0;
          if (key_press) begin
            state <= StPress1;
          end
        end

        // Release is checked first so it wins a tie with the long-press threshold.
        StPress1: begin
          if (key_release) begin
            state <= StWait2;
            cnt   <= '0;
          end else if (cnt == LONG_CNT - 26'd1) begin
            state         <= StLongHold;
            cnt           <= '0;
            evt.key_long  <= 1'b1;
            evt.key_valid <= 1'b1;
            evt.key_code  <= CodeLong;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end

        // A second press wins a tie with the double-click window timeout.
        StWait2: begin
          if (key_press) begin
            state <= StPress2;
            cnt   <= '0;
          end else if (cnt == DCLK_CNT - 26'd1) begin
            state         <= StIdle;
            cnt           <= '0;
            evt.key_short <= 1'b1;
            evt.key_valid <= 1'b1;
            evt.key_code  <= CodeShort;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end

        StPress2: begin
          cnt <= '0;
          if (key_release) begin
            state          <= StIdle;
            evt.key_double <= 1'b1;
            evt.key_valid  <= 1'b1;
            evt.key_code   <= CodeDouble;
          end
        end

        StLongHold: begin
          cnt <= '0;
          if (key_release) begin
            state        <= StIdle;
            evt.key_hold <= 1'b0;
          end else begin
            evt.key_hold <= 1'b1;
          end
        end

        default: begin
          state        <= StIdle;
          cnt          <= '0;
          evt.key_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus pushes expected events and level probes,
// a negedge monitor pops and compares them whenever the DUT presents an event.
module tb_key_event_decoder;

  localparam int LONG = 20;
  localparam int DCLK = 10;

  localparam logic [2:0] KShort  = 3'b100;
  localparam logic [2:0] KDouble = 3'b010;
  localparam logic [2:0] KLong   = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       hold;
    logic [1:0] code;
  } probe_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   cyc = 0;

  ev_t    ev_q[$];
  probe_t probe_q[$];

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int ev_pushed = 0;
  bit done = 1'b0;
  bit reported = 1'b0;

  key_event_if kif ();

  key_event_decoder #(
    .LONG_CNT(26'd20),
    .DCLK_CNT(26'd10)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .evt      (kif.master)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge sys_clk) begin
    ev_t        e;
    probe_t     pr;
    logic [2:0] kind_now;
    if (done) begin
      if (!reported) begin
        checks++;
        if (ev_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events: %0d expected events never seen", ev_q.size());
        end
        checks++;
        if (probe_q.size() != 0) begin
          errors++;
          $display("FAIL pending_probes: %0d probes never evaluated", probe_q.size());
        end
        checks++;
        if (valid_seen != ev_pushed) begin
          errors++;
          $display("FAIL valid_count: got %0d key_valid pulses, expected %0d",
                   valid_seen, ev_pushed);
        end
        reported = 1'b1;
      end
    end else begin
      while (probe_q.size() != 0 && probe_q[0].cyc < cyc) begin
        pr = probe_q.pop_front();
        checks++;
        errors++;
        $display("FAIL probe_missed: probe for cycle %0d not evaluated (now %0d)", pr.cyc, cyc);
      end
      if (probe_q.size() != 0 && probe_q[0].cyc == cyc) begin
        pr = probe_q.pop_front();
        checks++;
        if (kif.key_hold !== pr.hold || kif.key_code !== pr.code) begin
          errors++;
          $display("FAIL level_probe @%0d: hold=%b code=%b, expected hold=%b code=%b",
                   cyc, kif.key_hold, kif.key_code, pr.hold, pr.code);
        end
      end
      while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        checks++;
        errors++;
        $display("FAIL event_missed: kind=%b expected at cycle %0d, not observed", e.kind, e.cyc);
      end
      kind_now = {kif.key_short, kif.key_double, kif.key_long};
      if (kind_now != 3'b000 || kif.key_valid) begin
        if (kif.key_valid) valid_seen++;
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event @%0d: kind=%b valid=%b code=%b, expected none",
                   cyc, kind_now, kif.key_valid, kif.key_code);
        end else begin
          e = ev_q.pop_front();
          if (kind_now !== e.kind || kif.key_valid !== 1'b1 || kif.key_code !== e.code ||
              cyc != e.cyc) begin
            errors++;
            $display("FAIL event @%0d: kind=%b valid=%b code=%b, expected kind=%b valid=1 code=%b @%0d",
                     cyc, kind_now, kif.key_valid, kif.key_code, e.kind, e.code, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic [2:0] kind, input logic [1:0] code);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.code = code;
    ev_q.push_back(e);
    ev_pushed++;
  endtask

  task automatic push_probe(input int c, input logic hold, input logic [1:0] code);
    probe_t p;
    p.cyc  = c;
    p.hold = hold;
    p.code = code;
    probe_q.push_back(p);
  endtask

  // Press for low_len cycles (< LONG), release; short fires DCLK+1 after release detect.
  task automatic do_short(input int low_len, input int gap);
    int r;
    kif.key_filter = 1'b0;
    tick(low_len);
    r = cyc;
    kif.key_filter = 1'b1;
    push_ev(r + DCLK + 1, KShort, 2'b01);
    push_probe(r + DCLK + 2, 1'b0, 2'b01);
    tick(DCLK + 2 + gap);
  endtask

  // Press a, release b (<= DCLK), press c, release; double fires 1 after second release.
  task automatic do_double(input int a, input int b, input int c, input int gap);
    int r2;
    kif.key_filter = 1'b0;
    tick(a);
    kif.key_filter = 1'b1;
    tick(b);
    kif.key_filter = 1'b0;
    tick(c);
    r2 = cyc;
    kif.key_filter = 1'b1;
    push_ev(r2 + 1, KDouble, 2'b10);
    push_probe(r2 + 2, 1'b0, 2'b10);
    tick(2 + gap);
  endtask

  // Hold low_len (> LONG) cycles; long fires LONG+1 after press detect, hold follows.
  task automatic do_long(input int low_len, input int gap);
    int p;
    p = cyc;
    kif.key_filter = 1'b0;
    push_ev(p + LONG + 1, KLong, 2'b11);
    push_probe(p + LONG + 1, 1'b0, 2'b11);
    push_probe(p + LONG + 2, 1'b1, 2'b11);
    push_probe(p + low_len, 1'b1, 2'b11);
    push_probe(p + low_len + 1, 1'b0, 2'b11);
    tick(low_len);
    kif.key_filter = 1'b1;
    tick(2 + gap);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    kif.key_filter = 1'b1;

    // Reset state
    tick(1);
    push_probe(cyc, 1'b0, 2'b00);
    tick(2);
    sys_rst_n = 1'b1;
    push_probe(cyc, 1'b0, 2'b00);
    push_probe(cyc + 3, 1'b0, 2'b00);
    tick(5);

    // Short press
    do_short(5, 10);

    // Reset 3 cycles into a press: gesture aborted, code cleared, nothing emitted
    kif.key_filter = 1'b0;
    tick(3);
    sys_rst_n = 1'b0;
    kif.key_filter = 1'b1;
    push_probe(cyc, 1'b0, 2'b00);
    tick(2);
    sys_rst_n = 1'b1;
    tick(LONG + DCLK + 10);
    push_probe(cyc, 1'b0, 2'b00);
    tick(2);

    // Double click
    do_double(5, 4, 30, 10);

    // Long press
    do_long(40, 10);

    // Tie: release in the cnt==LONG-1 cycle -> short, not long
    do_short(LONG, 10);

    // Tie: second press in the cnt==DCLK-1 cycle -> double, not short
    do_double(5, DCLK, 5, 10);

    // Back-to-back gestures with 50 idle cycles between
    do_short(5, 50);
    do_long(40, 50);
    do_double(5, 4, 5, 50);

    tick(5);
    done = 1'b1;
    for (int i = 0; i < 10 && !reported; i++) tick(1);
    if (!reported) begin
      $display("FAIL monitor_report: monitor did not complete final checks");
      $fatal(1, "monitor stalled");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Downstream stage of the key debouncer; consumes its debounced, active-low key level (idle high, reset value 1).
- Classifies each key gesture as short press, double click or long press and emits one-cycle event pulses plus a held event code.
- The RS485 frame builder uses the event code to select which command frame to transmit.
- Runs on the 50 MHz system clock.

Parameters:
- LONG_CNT, 26'd50_000_000: press duration in cycles that qualifies as a long press (1 s at 50 MHz).
- DCLK_CNT, 26'd12_500_000: window in cycles after the first release in which a second press makes a double click (250 ms).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_filter  input  1  debounced key level; 0 = pressed, 1 = released.
- key_short  output  1  one-cycle pulse: short press classified.
- key_double  output  1  one-cycle pulse: double click classified.
- key_long  output  1  one-cycle pulse: long-press threshold reached.
- key_hold  output  1  level; high while the key stays held after a long press.
- key_valid  output  1  one-cycle pulse; coincides with any of key_short, key_double or key_long.
- key_code  output  2  last event: 00 none, 01 short, 10 double, 11 long; holds until the next event.

Behaviour:
- Reset, asynchronous on the falling edge of sys_rst_n: all pulse outputs 0, key_hold 0, key_code 00, state IDLE, counter 0, key_d 1.
- Reset mid-gesture aborts it silently; no event is emitted.
- Edge detect: key_d <= key_filter every cycle.
  - press = key_d & ~key_filter.
  - release = ~key_d & key_filter.
- Counter: 26 bits. It clears to 0 on every state entry and increments by 1 each cycle while in PRESS1 or WAIT2. It never wraps because the thresholds end the state first.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD.
- IDLE:
  - press -> PRESS1.
  - All other inputs are ignored, including a release that follows a reset taken while the key was held.
- PRESS1:
  - release -> WAIT2.
  - Otherwise, when cnt == LONG_CNT-1 -> LONG_HOLD, with key_long and key_valid pulsed and key_code = 11 on the transition edge.
  - If release and cnt == LONG_CNT-1 occur in the same cycle, release wins: WAIT2, no long event.
- WAIT2:
  - press -> PRESS2.
  - Otherwise, when cnt == DCLK_CNT-1 -> IDLE, with key_short and key_valid pulsed and key_code = 01.
  - If press and timeout occur in the same cycle, press wins: PRESS2, no short event.
- PRESS2:
  - release -> IDLE, with key_double and key_valid pulsed and key_code = 10.
  - There is no long-press detection in PRESS2, whatever the hold duration.
- LONG_HOLD:
  - key_hold = 1 (registered; high from the cycle after the transition).
  - release -> IDLE, key_hold = 0, no pulse.
- All outputs are registered.
- Latencies:
  - Pulses assert exactly 1 cycle after the triggering condition is sampled.
  - Long press: key_long asserts LONG_CNT+1 cycles after the press-detect cycle.
  - Short press: key_short asserts DCLK_CNT+1 cycles after the release-detect cycle.
- At most one event pulse is high in any cycle.
- key_code never returns to 00 except on reset.

Test Plan:
- Reset check: LONG_CNT=20, DCLK_CNT=10. Hold sys_rst_n low, then release it with key_filter=1 -> all outputs 0, key_code=00. Assert reset 3 cycles into a press -> no pulse afterwards, state IDLE.
- Short press: key_filter low for 5 cycles, then high -> key_short and key_valid high for exactly one cycle, 11 cycles after the release-detect cycle; key_code=01.
- Double click: press 5 cycles, release 4 cycles, press 30 cycles, release -> one key_double pulse 1 cycle after the second release; key_code=10; no key_short and no key_long.
- Long press: hold low for 40 cycles -> key_long pulse 21 cycles after the press-detect cycle; key_hold high from the next cycle until 1 cycle after release; no pulse on release; key_code=11.
- Boundary ties:
  - Release lands exactly in the cnt==19 cycle of PRESS1 -> no key_long; then short after the window.
  - Second press lands exactly in the cnt==9 cycle of WAIT2 -> no key_short; key_double on the following release.
- Back-to-back gestures: short, then long, then double, each separated by 50 idle cycles -> pulse sequence 01, 11, 10 on key_code; key_valid count = 3.
